mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single four-banked main memory between the instruction-cache controller (I) and the data-cache controller (D).
- Grants ownership to one requester at a time and holds it for a whole line fill or write-back.
- Blocks issue into a busy bank.
- Routes each read return to the requester that issued it, using an in-flight owner-tag pipeline.

Parameters:
- RD_LAT, 2: memory read latency in cycles from mem_rd issue to valid mem_data_out.
- AW, 16: address and data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req, d_req  in  1  requester wants ownership; held high for the whole line transaction.
- i_addr, d_addr  in  AW  word address.
- i_data_in, d_data_in  in  AW  write data.
- i_rd, d_rd, i_wr, d_wr  in  1  per-cycle access strobes; rd and wr are mutually exclusive per requester.
- i_grant, d_grant  out  1  registered ownership indication.
- i_stall, d_stall  out  1  access not accepted this cycle.
- i_data_out, d_data_out  out  AW  read return data.
- i_data_valid, d_data_valid  out  1  read return strobe.
- i_err, d_err  out  1  memory error for the accepted access.
- mem_addr, mem_data_in  out  AW  to memory.
- mem_rd, mem_wr  out  1  to memory.
- mem_data_out  in  AW  from memory.
- busy  in  4  per-bank busy flags.
- stall_mem  in  1  memory-wide stall.
- err  in  1  memory error for the current access.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; tag pipe cleared.
  - All grants, mem_rd, mem_wr, data_valid and err outputs are 0.
  - mem_addr and mem_data_in are 0.
  - X_stall = X_req, since no grant is held.
  - Reads in flight at reset are discarded.
- FSM states: IDLE, OWN_I, OWN_D.
  - IDLE: with both requests pending, go to OWN_D (fixed D priority, or per the optional feature). With one request, go to that requester. With none, stay in IDLE.
  - OWN_x: stay while x_req=1. On x_req=0, go to IDLE. Exactly one dead cycle always separates owners, including when the other requester is already waiting.
  - x_grant = 1 exactly when the state is OWN_x.
- Issue, combinational, from the owner only:
  - bank = owner_addr[2:1].
  - accept = (owner_rd | owner_wr) & ~busy[bank] & ~stall_mem.
  - On accept: drive mem_rd or mem_wr, mem_addr and mem_data_in from the owner.
  - Otherwise mem_rd = mem_wr = 0 and mem_addr and mem_data_in hold the owner's values.
- Stall:
  - Owner: owner_stall = (owner_rd | owner_wr) & ~accept.
  - Non-owner: x_stall = x_req.
  - rd or wr from a non-owner is ignored entirely.
- Error: err is passed combinationally to the owner's x_err only on an accepted cycle; the other x_err is 0.
- Tag pipe:
  - RD_LAT-stage shift register of {valid, owner}.
  - Stage 0 loads {accept & mem_rd, owner} every cycle.
  - At the last stage, valid drives owner_data_valid = 1 and owner_data_out = mem_data_out. The other requester's data_out is 0.
- Release while reads are in flight: allowed. Tags still route data to the original owner even after the grant has moved.
- Back-to-back reads: one accept per cycle; returns arrive in issue order.
- A write never enters the tag pipe.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_owner register (reset to I) records the most recent OWN state. On simultaneous requests in IDLE, the requester that was not last_owner wins.
- Undefined: D always wins simultaneous requests; no last_owner register exists.

Test Plan:
- I alone: i_req=1, i_rd=1, i_addr=0x0010, busy=0.
  - Cycle 1: i_grant=1.
  - Same cycle: mem_rd=1, mem_addr=0x0010.
  - RD_LAT cycles later: i_data_valid=1 with i_data_out = mem_data_out; d_data_valid stays 0.
- Simultaneous i_req=d_req=1 from IDLE.
  - d_grant=1, i_stall=1.
  - After d_req drops: one IDLE cycle, then i_grant=1.
  - With MEM_ARB_ROUND_ROBIN_EN and last_owner=D, I wins instead.
- Bank conflict: owner D, d_wr=1, d_addr=0x0006, busy=4'b1000.
  - Result: d_stall=1, mem_wr=0.
  - Next cycle with busy=0: mem_wr=1, d_stall=0.
- Release with reads in flight: D issues reads to 0x0000 and 0x0002, then drops d_req. I is granted two cycles later.
  - Both returns assert d_data_valid only, never i_data_valid.
- Error: owner I, accepted read with err=1.
  - Result: i_err=1, d_err=0.
  - Same err=1 on a stalled cycle: i_err=0.
- Reset mid-transfer: rst=0 while in OWN_I with 2 tags valid.
  - Grants, mem_rd and data_valid go to 0 immediately and stay 0.
  - After rst=1, no stale data_valid is produced.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose: shares one four-banked main memory between the I-cache and D-cache controllers. Optional build macro MEM_ARB_ROUND_ROBIN_EN makes simultaneous requests alternate instead of favouring D.
// Latency: grant appears one cycle after a request from IDLE. Issue to memory is combinational. A read return reaches its issuer RD_LAT cycles after issue.
// Backpressure: a busy bank or stall_mem stalls the owner, and a non-owner with a pending request is always stalled.
module mem_arbiter #(
    parameter int RD_LAT = 2,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic          d_req,
    input  logic [AW-1:0] i_addr,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] i_data_in,
    input  logic [AW-1:0] d_data_in,
    input  logic          i_rd,
    input  logic          d_rd,
    input  logic          i_wr,
    input  logic          d_wr,
    output logic          i_grant,
    output logic          d_grant,
    output logic          i_stall,
    output logic          d_stall,
    output logic [AW-1:0] i_data_out,
    output logic [AW-1:0] d_data_out,
    output logic          i_data_valid,
    output logic          d_data_valid,
    output logic          i_err,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_data_in,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [AW-1:0] mem_data_out,
    input  logic [3:0]    busy,
    input  logic          stall_mem,
    input  logic          err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_I = 2'd1;
    localparam logic [1:0] OWN_D = 2'd2;

    // Owner encoding shared by last_owner and the tag pipe: 0 = I, 1 = D.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              own_i;
    logic              own_d;
    logic              owner_sel;
    logic              owner_rd;
    logic              owner_wr;
    logic [AW-1:0]     owner_addr;
    logic [AW-1:0]     owner_wdat;
    logic [1:0]        bank;
    logic              accept;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_own;
    logic              ret_vld;
    logic              ret_own;
    logic              both_pick;

    assign own_i = (state == OWN_I);
    assign own_d = (state == OWN_D);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_owner;

    // Remember which side held the memory most recently so a tie goes to the other side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= OWNER_I;
        end else if (own_i) begin
            last_owner <= OWNER_I;
        end else if (own_d) begin
            last_owner <= OWNER_D;
        end
    end

    assign both_pick = ~last_owner;
`else
    assign both_pick = OWNER_D;
`endif

    // Ownership FSM: hold for the whole line, one dead IDLE cycle between owners.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    state_nxt = (both_pick == OWNER_D) ? OWN_D : OWN_I;
                end else if (d_req) begin
                    state_nxt = OWN_D;
                end else if (i_req) begin
                    state_nxt = OWN_I;
                end
            end
            OWN_I:   state_nxt = i_req ? OWN_I : IDLE;
            OWN_D:   state_nxt = d_req ? OWN_D : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; grants are decoded straight from it so they are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Select the owner's access; in IDLE nothing is driven so memory sees zeros.
    always_comb begin
        owner_sel  = OWNER_I;
        owner_rd   = 1'b0;
        owner_wr   = 1'b0;
        owner_addr = '0;
        owner_wdat = '0;
        if (own_i) begin
            owner_sel  = OWNER_I;
            owner_rd   = i_rd;
            owner_wr   = i_wr;
            owner_addr = i_addr;
            owner_wdat = i_data_in;
        end else if (own_d) begin
            owner_sel  = OWNER_D;
            owner_rd   = d_rd;
            owner_wr   = d_wr;
            owner_addr = d_addr;
            owner_wdat = d_data_in;
        end
    end

    assign bank   = owner_addr[2:1];
    assign accept = (owner_rd | owner_wr) & ~busy[bank] & ~stall_mem;

    assign mem_rd      = accept & owner_rd;
    assign mem_wr      = accept & owner_wr;
    assign mem_addr    = owner_addr;
    assign mem_data_in = owner_wdat;

    assign i_grant = own_i;
    assign d_grant = own_d;

    // A non-owner's strobes are ignored; it simply waits while it requests.
    assign i_stall = own_i ? ((i_rd | i_wr) & ~accept) : i_req;
    assign d_stall = own_d ? ((d_rd | d_wr) & ~accept) : d_req;

    assign i_err = own_i & accept & err;
    assign d_err = own_d & accept & err;

    // Owner-tag pipe: records who issued each accepted read so the return follows the issuer even after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld[0] <= mem_rd;
            tag_own[0] <= owner_sel;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_own[k] <= tag_own[k-1];
            end
        end
    end

    assign ret_vld = tag_vld[RD_LAT-1];
    assign ret_own = tag_own[RD_LAT-1];

    assign i_data_valid = ret_vld & (ret_own == OWNER_I);
    assign d_data_valid = ret_vld & (ret_own == OWNER_D);
    assign i_data_out   = i_data_valid ? mem_data_out : '0;
    assign d_data_out   = d_data_valid ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter; inputs change on the falling edge and are checked 1 time unit later.
// Latency: each step is one clock; read returns are expected RD_LAT (2) cycles after issue.
// Backpressure: busy and stall_mem are driven directly to exercise owner stalls.
module tb_mem_arbiter;

    localparam int AW = 16;

    logic          clk;
    logic          rst;
    logic          i_req, d_req;
    logic [AW-1:0] i_addr, d_addr, i_data_in, d_data_in;
    logic          i_rd, d_rd, i_wr, d_wr;
    logic          i_grant, d_grant, i_stall, d_stall;
    logic [AW-1:0] i_data_out, d_data_out;
    logic          i_data_valid, d_data_valid, i_err, d_err;
    logic [AW-1:0] mem_addr, mem_data_in;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_data_out;
    logic [3:0]    busy;
    logic          stall_mem;
    logic          err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.RD_LAT(2), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .d_req(d_req),
        .i_addr(i_addr), .d_addr(d_addr),
        .i_data_in(i_data_in), .d_data_in(d_data_in),
        .i_rd(i_rd), .d_rd(d_rd), .i_wr(i_wr), .d_wr(d_wr),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_stall(i_stall), .d_stall(d_stall),
        .i_data_out(i_data_out), .d_data_out(d_data_out),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .i_err(i_err), .d_err(d_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out),
        .busy(busy), .stall_mem(stall_mem), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        i_req = 1'b1; d_req = 1'b0;
        i_addr = '0; d_addr = '0; i_data_in = '0; d_data_in = '0;
        i_rd = 1'b0; d_rd = 1'b0; i_wr = 1'b0; d_wr = 1'b0;
        mem_data_out = '0; busy = '0; stall_mem = 1'b0; err = 1'b0;

        // Reset state
        step(); #1;
        chk("rst_i_grant", {15'd0, i_grant}, 16'd0);
        chk("rst_d_grant", {15'd0, d_grant}, 16'd0);
        chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_i_stall", {15'd0, i_stall}, 16'd1);
        chk("rst_d_stall", {15'd0, d_stall}, 16'd0);
        chk("rst_i_dv", {15'd0, i_data_valid}, 16'd0);

        // I alone: request in IDLE, grant next cycle with read issued
        step(); rst = 1'b1; i_req = 1'b1; i_rd = 1'b1; i_addr = 16'h0010; #1;
        chk("idle_i_grant", {15'd0, i_grant}, 16'd0);
        chk("idle_mem_rd", {15'd0, mem_rd}, 16'd0);
        step(); #1;
        chk("i_alone_grant", {15'd0, i_grant}, 16'd1);
        chk("i_alone_mem_rd", {15'd0, mem_rd}, 16'd1);
        chk("i_alone_mem_addr", mem_addr, 16'h0010);
        chk("i_alone_stall", {15'd0, i_stall}, 16'd0);
        step(); i_rd = 1'b0; #1;
        chk("i_alone_early_dv", {15'd0, i_data_valid}, 16'd0);
        step(); mem_data_out = 16'hBEEF; #1;
        chk("i_alone_dv", {15'd0, i_data_valid}, 16'd1);
        chk("i_alone_dout", i_data_out, 16'hBEEF);
        chk("i_alone_d_dv", {15'd0, d_data_valid}, 16'd0);
        chk("i_alone_d_dout", d_data_out, 16'h0000);
        step(); i_req = 1'b0; #1;
        chk("i_alone_dv_once", {15'd0, i_data_valid}, 16'd0);

        // Simultaneous requests from IDLE: D wins in the default build
        step(); i_req = 1'b1; d_req = 1'b1; #1;
        chk("sim_idle_grants", {14'd0, i_grant, d_grant}, 16'd0);
        step();
        // Bank conflict: D writes 0x0006 (bank 3) while bank 3 is busy
        d_wr = 1'b1; d_addr = 16'h0006; d_data_in = 16'h1234; busy = 4'b1000; #1;
        chk("sim_d_grant", {15'd0, d_grant}, 16'd1);
        chk("sim_i_grant", {15'd0, i_grant}, 16'd0);
        chk("sim_i_stall", {15'd0, i_stall}, 16'd1);
        chk("conf_d_stall", {15'd0, d_stall}, 16'd1);
        chk("conf_mem_wr", {15'd0, mem_wr}, 16'd0);
        chk("conf_mem_addr", mem_addr, 16'h0006);
        step(); busy = 4'b0000; #1;
        chk("conf_clr_mem_wr", {15'd0, mem_wr}, 16'd1);
        chk("conf_clr_d_stall", {15'd0, d_stall}, 16'd0);
        chk("conf_clr_wdata", mem_data_in, 16'h1234);
        step(); d_wr = 1'b0; d_req = 1'b0; #1;
        chk("hold_d_grant", {15'd0, d_grant}, 16'd1);
        step(); #1;
        chk("dead_i_grant", {15'd0, i_grant}, 16'd0);
        chk("dead_d_grant", {15'd0, d_grant}, 16'd0);
        chk("wr_no_return", {14'd0, i_data_valid, d_data_valid}, 16'd0);
        step(); #1;
        chk("handover_i_grant", {15'd0, i_grant}, 16'd1);

        // Error: accepted read passes err to I only; stalled cycle masks it
        i_rd = 1'b1; i_addr = 16'h0008; err = 1'b1; #1;
        chk("err_i_err", {15'd0, i_err}, 16'd1);
        chk("err_d_err", {15'd0, d_err}, 16'd0);
        step(); busy = 4'b0001; #1;
        chk("err_stall_i_stall", {15'd0, i_stall}, 16'd1);
        chk("err_stall_i_err", {15'd0, i_err}, 16'd0);
        chk("err_stall_mem_rd", {15'd0, mem_rd}, 16'd0);
        step(); i_rd = 1'b0; busy = 4'b0000; err = 1'b0; i_req = 1'b0; mem_data_out = 16'h5555; #1;
        chk("err_rd_dv", {15'd0, i_data_valid}, 16'd1);
        chk("err_rd_dout", i_data_out, 16'h5555);

        // Release with reads in flight: returns must follow D after I takes over
        step(); d_req = 1'b1; #1;
        chk("rel_idle", {14'd0, i_grant, d_grant}, 16'd0);
        step(); d_rd = 1'b1; d_addr = 16'h0000; #1;
        chk("rel_rd0", {15'd0, mem_rd}, 16'd1);
        step(); d_addr = 16'h0002; i_req = 1'b1; #1;
        chk("rel_rd1", {15'd0, mem_rd}, 16'd1);
        chk("rel_rd1_addr", mem_addr, 16'h0002);
        step(); d_rd = 1'b0; d_req = 1'b0; mem_data_out = 16'hA0A0; #1;
        chk("rel_ret0_d", {15'd0, d_data_valid}, 16'd1);
        chk("rel_ret0_i", {15'd0, i_data_valid}, 16'd0);
        chk("rel_ret0_dout", d_data_out, 16'hA0A0);
        step(); mem_data_out = 16'hA2A2; #1;
        chk("rel_ret1_d", {15'd0, d_data_valid}, 16'd1);
        chk("rel_ret1_i", {15'd0, i_data_valid}, 16'd0);
        chk("rel_ret1_dout", d_data_out, 16'hA2A2);
        chk("rel_dead_i_grant", {15'd0, i_grant}, 16'd0);
        step(); i_rd = 1'b1; i_addr = 16'h0010; #1;
        chk("rel_i_grant", {15'd0, i_grant}, 16'd1);
        chk("rel_no_more_d", {15'd0, d_data_valid}, 16'd0);

        // Reset mid-transfer with two I reads in flight
        step(); #1;
        chk("mid_rd", {15'd0, mem_rd}, 16'd1);
        step(); #1;
        chk("mid_pre_rst_dv", {15'd0, i_data_valid}, 16'd1);
        rst = 1'b0; #1;
        chk("mid_rst_grant", {15'd0, i_grant}, 16'd0);
        chk("mid_rst_mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("mid_rst_dv", {15'd0, i_data_valid}, 16'd0);
        chk("mid_rst_i_stall", {15'd0, i_stall}, 16'd1);
        step(); #1;
        chk("mid_rst_hold", {13'd0, i_grant, mem_rd, i_data_valid}, 16'd0);
        step(); rst = 1'b1; i_req = 1'b0; i_rd = 1'b0; #1;
        for (int c = 0; c < 3; c++) begin
            chk("post_rst_no_dv", {14'd0, i_data_valid, d_data_valid}, 16'd0);
            step(); #1;
        end

`ifdef MEM_ARB_ROUND_ROBIN_EN
        // D owns once, then a tie goes to I
        d_req = 1'b1;
        step(); d_req = 1'b0; #1;
        chk("rr_d_first", {15'd0, d_grant}, 16'd1);
        step(); i_req = 1'b1; d_req = 1'b1; #1;
        step(); #1;
        chk("rr_i_wins", {15'd0, i_grant}, 16'd1);
        chk("rr_d_waits", {15'd0, d_stall}, 16'd1);
        i_req = 1'b0; d_req = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
